player_bullet_controller: RTL
=============================

# player_bullet_controller

Owns the player's bullet pool: allocates slots on fire requests, advances active bullets up the screen once per frame, and retires them on enemy hit or screen exit. It drives the flattened bullet position/active buses consumed by the enemy hit detector and consumes that detector's per-bullet `bullet_hit` pulses. It sits between player input/position logic and enemy collision logic, all on the 25 MHz pixel clock.

## Interface
Parameters:
- `BULLET_COUNT`, 8: number of bullet slots; must match the enemy hit detector.
- `BULLET_SPEED`, 4: pixels moved upward per frame tick.
- `FIRE_COOLDOWN`, 12: frame ticks between accepted shots.
- `X_OFFSET`, 16: added to `player_x` at spawn (centre of the 32-px sprite).

Ports:
- `clk25`  in  1  pixel clock; only clock.
- `reset`  in  1  synchronous, active-high reset.
- `frame_tick`  in  1  one-cycle pulse per video frame.
- `fire`  in  1  level fire request from player input.
- `player_x`  in  10  player sprite left edge.
- `player_y`  in  10  player sprite top edge.
- `bullet_hit`  in  BULLET_COUNT  per-slot hit pulse from enemy hit detector.
- `bullet_x_flat`  out  10*BULLET_COUNT  slot j x at bits `[j*10 +: 10]`.
- `bullet_y_flat`  out  10*BULLET_COUNT  slot j y at bits `[j*10 +: 10]`.
- `bullet_active_flat`  out  BULLET_COUNT  slot j active at bit j.
- `fire_ack`  out  1  one-cycle pulse when a shot is spawned.
- `free_count`  out  4  number of inactive slots (0..BULLET_COUNT).

## Operation
- Per slot: x/y (10 b), active. Global: cooldown counter (4 b, saturating at 0).
- Hit: `bullet_hit[j]` high in any cycle with slot j active clears active at the next edge; x/y are held. Hits on inactive slots are ignored. Hit takes priority over movement in the same cycle.
- Move (on `frame_tick` only): each active, not-hit slot that was not spawned this tick: if y < BULLET_SPEED, clear active (no wrap below 0); else y <= y − BULLET_SPEED. x is unchanged.
- Spawn (on `frame_tick` only): if `fire`=1, cooldown=0, and at least one slot is inactive *at the start of the cycle*, the lowest-index inactive slot gets x = player_x + X_OFFSET (mod 1024), y = player_y, active=1; cooldown <= FIRE_COOLDOWN; `fire_ack`=1 next cycle. Slots freed by a hit or an off-screen exit in the same cycle are not eligible until the following tick.
- No free slot, or cooldown ≠ 0: request ignored, no ack, cooldown not reloaded.
- Cooldown: decrements by 1 on each `frame_tick` when nonzero and no spawn occurs.
- `free_count` = popcount of ~active, registered, and updated the cycle after any active change.
- Reset: all active=0, x=y=0, cooldown=0, `fire_ack`=0, `free_count`=BULLET_COUNT. Reset mid-flight discards all bullets immediately; a same-cycle `frame_tick` is ignored.

## Timing
- All outputs are registered; state changes are visible one cycle after the causing edge.
- Positions change only on the cycle after `frame_tick`, so they are stable for the hit detector's one-cycle registered compare. A hit pulse arrives at most one cycle after overlap and is honoured even if it lands in the cycle after `frame_tick`.
- `fire_ack` is high for exactly one cycle per spawn; at most one spawn per frame.
- `frame_tick` asserted on consecutive cycles is processed each cycle, with no merging.

## Structure
- Shared package: `SCREEN_W`=640, `SCREEN_H`=480, `SPRITE_SIZE`=32, `BULLET_COUNT`, and the 10-bit coordinate width, all shared with the enemy controller and renderer.
- Sub-module `bullet_slot_alloc`: combinational lowest-index-free priority encoder over the active vector, outputting `found` and `idx`. Everything else lives in the top module.

## Test plan
- Reset, then `fire`=1 with player=(300,400), one `frame_tick` → slot 0 active at (316,400), `fire_ack` pulses once, `free_count`=7.
- Hold `fire` for 30 ticks → spawns on ticks 0, 13, 26 only (slots 0, 1, 2); slot 0 y = 400−4·k after tick k.
- Slot at y=3 with a tick → deactivated, not wrapped to 1023; `free_count` increments.
- All 8 slots active with `fire` held for a tick → no spawn, no ack, cooldown unchanged. Pulse `bullet_hit[5]` → slot 5 inactive. The next eligible tick spawns into slot 5.
- `bullet_hit[2]` and `frame_tick` in the same cycle, with slot 2 active and free slots existing → slot 2 cleared and not moved; spawn goes to the lowest slot free before that cycle, not slot 2.
- Assert `reset` while 4 bullets are in flight alongside a `frame_tick` → next cycle all inactive, x=y=0, `free_count`=8, no `fire_ack`.

Source files
------------

// File: rtl/player_bullet_controller_pkg.sv
// Constants and types shared by the player bullet pool, the enemy controller and the renderer.
package player_bullet_controller_pkg;

  localparam int unsigned SCREEN_W     = 640;
  localparam int unsigned SCREEN_H     = 480;
  localparam int unsigned SPRITE_SIZE  = 32;
  localparam int unsigned BULLET_COUNT = 8;
  localparam int unsigned COORD_W      = 10;

  typedef logic [COORD_W-1:0] coord_t;

  // Coordinate addition that wraps modulo 2**COORD_W.
  function automatic coord_t coord_add(input coord_t a, input int unsigned b);
    return a + coord_t'(b);
  endfunction

endpackage

// File: rtl/bullet_slot_alloc.sv
// Lowest-index free-slot priority encoder over the bullet active vector.
module bullet_slot_alloc #(
  parameter int unsigned N    = 8,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    active,
  output logic            found,
  output logic [IdxW-1:0] idx
);

  always_comb begin
    found = 1'b0;
    idx   = '0;
    // Scan downwards so the lowest free index is the last one written.
    for (int j = int'(N) - 1; j >= 0; j--) begin
      if (!active[j]) begin
        found = 1'b1;
        idx   = IdxW'(j);
      end
    end
  end

endmodule

// File: rtl/player_bullet_controller.sv
// Player bullet pool: spawns shots on frame ticks, moves them upward, retires on hit or exit.
module player_bullet_controller
  import player_bullet_controller_pkg::*;
#(
  parameter int unsigned BULLET_COUNT  = 8,
  parameter int unsigned BULLET_SPEED  = 4,
  parameter int unsigned FIRE_COOLDOWN = 12,
  parameter int unsigned X_OFFSET      = 16
) (
  input  logic                            clk25,
  input  logic                            reset,
  input  logic                            frame_tick,
  input  logic                            fire,
  input  logic [COORD_W-1:0]              player_x,
  input  logic [COORD_W-1:0]              player_y,
  input  logic [BULLET_COUNT-1:0]         bullet_hit,
  output logic [COORD_W*BULLET_COUNT-1:0] bullet_x_flat,
  output logic [COORD_W*BULLET_COUNT-1:0] bullet_y_flat,
  output logic [BULLET_COUNT-1:0]         bullet_active_flat,
  output logic                            fire_ack,
  output logic [3:0]                      free_count
);

  localparam int unsigned IdxW         = (BULLET_COUNT > 1) ? $clog2(BULLET_COUNT) : 1;
  localparam logic [3:0]  CooldownLoad = 4'(FIRE_COOLDOWN);
  localparam coord_t      Speed        = coord_t'(BULLET_SPEED);
  localparam logic [3:0]  AllFree      = 4'(BULLET_COUNT);

  coord_t                  x_q [BULLET_COUNT];
  coord_t                  x_d [BULLET_COUNT];
  coord_t                  y_q [BULLET_COUNT];
  coord_t                  y_d [BULLET_COUNT];
  logic [BULLET_COUNT-1:0] active_q, active_d;
  logic [3:0]              cooldown_q, cooldown_d;
  logic                    fire_ack_q, fire_ack_d;
  logic [3:0]              free_count_q, free_count_d;

  logic                    slot_found;
  logic [IdxW-1:0]         slot_idx;
  logic                    spawn;

  // Allocation looks at the active vector at the start of the cycle, so slots freed this
  // cycle by a hit or an exit only become eligible on the following tick.
  bullet_slot_alloc #(
    .N    (BULLET_COUNT),
    .IdxW (IdxW)
  ) u_slot_alloc (
    .active (active_q),
    .found  (slot_found),
    .idx    (slot_idx)
  );

  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    active_d   = active_q;
    cooldown_d = cooldown_q;
    spawn      = frame_tick && fire && (cooldown_q == 4'd0) && slot_found;

    for (int j = 0; j < int'(BULLET_COUNT); j++) begin
      if (active_q[j]) begin
        if (bullet_hit[j]) begin
          active_d[j] = 1'b0;
        end else if (frame_tick) begin
          // Leaving the top of the screen retires the bullet instead of wrapping.
          if (y_q[j] < Speed) begin
            active_d[j] = 1'b0;
          end else begin
            y_d[j] = y_q[j] - Speed;
          end
        end
      end
    end

    // The spawn slot was inactive, so the movement loop above never touched it.
    if (spawn) begin
      x_d[slot_idx]      = coord_add(player_x, X_OFFSET);
      y_d[slot_idx]      = player_y;
      active_d[slot_idx] = 1'b1;
      cooldown_d         = CooldownLoad;
    end else if (frame_tick && (cooldown_q != 4'd0)) begin
      cooldown_d = cooldown_q - 4'd1;
    end

    fire_ack_d = spawn;

    free_count_d = 4'd0;
    for (int j = 0; j < int'(BULLET_COUNT); j++) begin
      if (!active_d[j]) begin
        free_count_d = free_count_d + 4'd1;
      end
    end
  end

  always_ff @(posedge clk25) begin
    if (reset) begin
      x_q          <= '{default: '0};
      y_q          <= '{default: '0};
      active_q     <= '0;
      cooldown_q   <= 4'd0;
      fire_ack_q   <= 1'b0;
      free_count_q <= AllFree;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      active_q     <= active_d;
      cooldown_q   <= cooldown_d;
      fire_ack_q   <= fire_ack_d;
      free_count_q <= free_count_d;
    end
  end

  for (genvar g = 0; g < int'(BULLET_COUNT); g++) begin : g_flatten
    assign bullet_x_flat[g*COORD_W +: COORD_W] = x_q[g];
    assign bullet_y_flat[g*COORD_W +: COORD_W] = y_q[g];
  end

  assign bullet_active_flat = active_q;
  assign fire_ack           = fire_ack_q;
  assign free_count         = free_count_q;

endmodule
